// File: rtl/synth_pkg.sv
// Shared types for the jingle sequencer: controller state and request source.
package synth_pkg;

  // Controller states. START is the single cycle in which the command strobe is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  // Who asked for the jingle currently in flight.
  typedef enum logic {
    SRC_MANUAL = 1'b0,
    SRC_AUTO   = 1'b1
  } seq_src_t;

  // Smallest silent gap the counter scheme can represent.
  localparam int GAP_CYCLES_MIN = 2;

  // Next playlist index, wrapping with an explicit compare so the table
  // length need not be a power of two.
  function automatic int next_index(input int pos, input int len);
    if (pos >= len - 1) begin
      return 0;
    end else begin
      return pos + 1;
    end
  endfunction

endpackage

// File: rtl/seq_playlist_ram.sv
// Playlist register file: SEQ_LEN entries of NUM_W bits, synchronous write,
// asynchronous read, and reset contents entry i = i mod JINGLE_CNT.
module seq_playlist_ram #(
  parameter int JINGLE_CNT = 8,
  parameter int SEQ_LEN    = 8,
  parameter int NUM_W      = $clog2(JINGLE_CNT),
  parameter int POS_W      = $clog2(SEQ_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wr_addr,
  input  logic [NUM_W-1:0] wr_data,
  input  logic [POS_W-1:0] rd_addr,
  output logic [NUM_W-1:0] rd_data
);

  localparam int ADDR_W = POS_W + 1;
  localparam logic [ADDR_W-1:0] ENTRY_LIMIT = ADDR_W'(SEQ_LEN);

  logic [NUM_W-1:0] mem [SEQ_LEN];
  logic             wr_ok;

  // Drop writes aimed past the end of a non-power-of-two table.
  always_comb begin
    wr_ok = 1'b0;
    if (wr_en && ({1'b0, wr_addr} < ENTRY_LIMIT)) begin
      wr_ok = 1'b1;
    end else begin
      wr_ok = 1'b0;
    end
  end

  // Table storage: default ramp on reset, otherwise accept the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        mem[i] <= NUM_W'(i % JINGLE_CNT);
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read is combinational so a same-cycle write is seen only from the next cycle.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/jingle_sequencer.sv
// Jingle sequencer: chooses the next jingle for audio_send from manual key
// requests or a programmable playlist, and paces playlist entries with a
// fixed silent gap.
module jingle_sequencer
  import synth_pkg::*;
#(
  parameter int JINGLE_CNT = 8,
  parameter int SEQ_LEN    = 8,
  parameter int GAP_CYCLES = 48000,
  parameter int NUM_W      = $clog2(JINGLE_CNT),
  parameter int POS_W      = $clog2(SEQ_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             auto_mode_i,
  input  logic [NUM_W-1:0] key_num_i,
  input  logic             key_num_val_i,
  input  logic             prog_wr_i,
  input  logic [POS_W-1:0] prog_addr_i,
  input  logic [NUM_W-1:0] prog_data_i,
  input  logic             jingle_done_i,
  output logic [NUM_W-1:0] jingle_num_o,
  output logic             jingle_num_val_o,
  output logic             busy_o,
  output logic [POS_W-1:0] seq_pos_o
);

  localparam int CNT_W = $clog2(GAP_CYCLES);
  localparam int KEY_W = NUM_W + 1;
  localparam logic [KEY_W-1:0] KEY_LIMIT = KEY_W'(JINGLE_CNT);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       state;
  seq_src_t         src;
  logic [CNT_W-1:0] gap_cnt;

  logic             key_ok;
  logic [POS_W-1:0] next_pos;
  logic [POS_W-1:0] rd_addr;
  logic [NUM_W-1:0] rd_data;

  seq_playlist_ram #(
    .JINGLE_CNT (JINGLE_CNT),
    .SEQ_LEN    (SEQ_LEN),
    .NUM_W      (NUM_W),
    .POS_W      (POS_W)
  ) u_playlist (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (prog_wr_i),
    .wr_addr (prog_addr_i),
    .wr_data (prog_data_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Request qualification, playlist wrap and the playlist read address.
  // In GAP the entry to latch is the one after the current position; in
  // IDLE it is the current position itself.
  always_comb begin
    key_ok   = 1'b0;
    next_pos = seq_pos_o;
    rd_addr  = seq_pos_o;
    if (key_num_val_i && ({1'b0, key_num_i} < KEY_LIMIT)) begin
      key_ok = 1'b1;
    end else begin
      key_ok = 1'b0;
    end
    if (seq_pos_o == LAST_POS) begin
      next_pos = {POS_W{1'b0}};
    end else begin
      next_pos = seq_pos_o + POS_W'(1);
    end
    if (state == GAP) begin
      rd_addr = next_pos;
    end else begin
      rd_addr = seq_pos_o;
    end
  end

  // Controller FSM with gap counter and registered command outputs.
  // Entering START always loads the number and raises the strobe, so the
  // strobe lasts exactly the one START cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      src              <= SRC_MANUAL;
      gap_cnt          <= {CNT_W{1'b0}};
      seq_pos_o        <= {POS_W{1'b0}};
      jingle_num_o     <= {NUM_W{1'b0}};
      jingle_num_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      jingle_num_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (key_ok) begin
            state            <= START;
            src              <= SRC_MANUAL;
            jingle_num_o     <= key_num_i;
            jingle_num_val_o <= 1'b1;
            busy_o           <= 1'b1;
          end else if (auto_mode_i) begin
            state            <= START;
            src              <= SRC_AUTO;
            jingle_num_o     <= rd_data;
            jingle_num_val_o <= 1'b1;
            busy_o           <= 1'b1;
          end else begin
            busy_o           <= 1'b0;
          end
        end
        START: begin
          // Key strobes and done pulses are deliberately not looked at here.
          state  <= PLAY;
          busy_o <= 1'b1;
        end
        PLAY: begin
          if (key_ok) begin
            // A key beats a coincident done pulse and preempts the jingle.
            state            <= START;
            src              <= SRC_MANUAL;
            jingle_num_o     <= key_num_i;
            jingle_num_val_o <= 1'b1;
            busy_o           <= 1'b1;
          end else if (jingle_done_i) begin
            if ((src == SRC_AUTO) && auto_mode_i) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
              busy_o  <= 1'b1;
            end else begin
              state   <= IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            busy_o <= 1'b1;
          end
        end
        GAP: begin
          if (key_ok) begin
            // Preemption leaves the playlist position where it was.
            state            <= START;
            src              <= SRC_MANUAL;
            jingle_num_o     <= key_num_i;
            jingle_num_val_o <= 1'b1;
            busy_o           <= 1'b1;
          end else if (!auto_mode_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (gap_cnt == {CNT_W{1'b0}}) begin
            state            <= START;
            src              <= SRC_AUTO;
            seq_pos_o        <= next_pos;
            jingle_num_o     <= rd_data;
            jingle_num_val_o <= 1'b1;
            busy_o           <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
            busy_o  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jingle_sequencer.sv
// Self-checking bench for jingle_sequencer: directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_jingle_sequencer;

  localparam int JC = 6;   // fewer jingles than key codes, so keys 6 and 7 are out of range
  localparam int SL = 6;   // non-power-of-two playlist length
  localparam int GC = 4;
  localparam int NW = 3;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          auto_mode;
  logic [NW-1:0] key;
  logic          key_val;
  logic          prog_wr;
  logic [PW-1:0] prog_addr;
  logic [NW-1:0] prog_data;
  logic          done;
  logic [NW-1:0] jnum;
  logic          jval;
  logic          busy;
  logic [PW-1:0] pos;

  int checks = 0;
  int failures = 0;

  // Behavioural model: what is playing, how many silent edges remain, and the playlist.
  int m_list [SL];
  int m_pos, m_num, m_gap_left;
  bit m_val, m_active, m_fresh, m_in_gap, m_auto_src;

  jingle_sequencer #(
    .JINGLE_CNT (JC),
    .SEQ_LEN    (SL),
    .GAP_CYCLES (GC)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .auto_mode_i      (auto_mode),
    .key_num_i        (key),
    .key_num_val_i    (key_val),
    .prog_wr_i        (prog_wr),
    .prog_addr_i      (prog_addr),
    .prog_data_i      (prog_data),
    .jingle_done_i    (done),
    .jingle_num_o     (jnum),
    .jingle_num_val_o (jval),
    .busy_o           (busy),
    .seq_pos_o        (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int v, input bit from_auto);
    m_num      = v;
    m_val      = 1'b1;
    m_active   = 1'b1;
    m_fresh    = 1'b1;
    m_in_gap   = 1'b0;
    m_auto_src = from_auto;
  endtask

  // One clock edge of the rules, applied to the inputs present at that edge.
  task automatic model_step();
    bit ok;
    ok = key_val && (int'(key) < JC);
    if (rst) begin
      for (int i = 0; i < SL; i++) m_list[i] = i % JC;
      m_pos = 0; m_num = 0; m_gap_left = 0;
      m_val = 0; m_active = 0; m_fresh = 0; m_in_gap = 0; m_auto_src = 0;
    end else begin
      m_val = 1'b0;
      if (!m_active) begin
        if (ok) issue(int'(key), 1'b0);
        else if (auto_mode) issue(m_list[m_pos], 1'b1);
      end else if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (!m_in_gap) begin
        if (ok) issue(int'(key), 1'b0);
        else if (done) begin
          if (m_auto_src && auto_mode) begin
            m_in_gap   = 1'b1;
            m_gap_left = GC;
          end else begin
            m_active = 1'b0;
          end
        end
      end else begin
        if (ok) issue(int'(key), 1'b0);
        else if (!auto_mode) begin
          m_active = 1'b0;
          m_in_gap = 1'b0;
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_pos = (m_pos + 1) % SL;
            issue(m_list[m_pos], 1'b1);
          end
        end
      end
      // Writes land after this edge's read, so a same-cycle latch sees the old value.
      if (prog_wr) m_list[prog_addr] = int'(prog_data);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("val", 32'(jval), 32'(m_val));
    chk("num", 32'(jnum), 32'(m_num));
    chk("busy", 32'(busy), 32'(m_active));
    chk("pos", 32'(pos), 32'(m_pos));
    key_val = 1'b0;
    done    = 1'b0;
    prog_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n, output logic [NW-1:0] num);
    bit found;
    found = 1'b0;
    n = 0;
    num = '0;
    while (!found && n < budget) begin
      cycle();
      n++;
      if (jval) begin
        found = 1'b1;
        num = jnum;
      end
    end
    chk("strobe_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int n;
    logic [NW-1:0] num;
    rst = 1'b1; auto_mode = 1'b0; key = '0; key_val = 1'b0;
    prog_wr = 1'b0; prog_addr = '0; prog_data = '0; done = 1'b0;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_val", 32'(jval), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);

    // Manual request: strobe exactly one cycle after the key, then done -> idle
    repeat (3) cycle();
    key = 3'd5; key_val = 1'b1;
    cycle();
    chk("man_val", 32'(jval), 32'd1);
    chk("man_num", 32'(jnum), 32'd5);
    cycle();
    chk("man_val_once", 32'(jval), 32'd0);
    chk("man_busy", 32'(busy), 32'd1);
    cycle();
    done = 1'b1;
    cycle();
    chk("man_idle", 32'(busy), 32'd0);

    // Auto playlist: default entries in order, GC+1 cycles from done to strobe, wrap
    auto_mode = 1'b1;
    wait_strobe(4, n, num);
    chk("auto_first", 32'(num), 32'd0);
    for (int e = 1; e <= 7; e++) begin
      cycle(); cycle();
      done = 1'b1;
      cycle();
      wait_strobe(GC + 4, n, num);
      chk("auto_gap_len", 32'(n), 32'(GC));
      chk("auto_num", 32'(num), 32'(e % SL));
      chk("auto_pos", 32'(pos), 32'(e % SL));
    end

    // Preemption during the gap after entry 2
    cycle(); cycle(); done = 1'b1; cycle();
    wait_strobe(GC + 4, n, num);
    chk("pre_entry", 32'(num), 32'd2);
    cycle(); cycle(); done = 1'b1; cycle();
    cycle();
    key = 3'd6 - 3'd1; key_val = 1'b1;
    cycle();
    chk("pre_val", 32'(jval), 32'd1);
    chk("pre_num", 32'(jnum), 32'd5);
    chk("pre_pos", 32'(pos), 32'd2);
    cycle(); cycle(); done = 1'b1; cycle();
    wait_strobe(GC + 4, n, num);

    // Mode drop in the gap -> idle, and a done pulse in idle does nothing
    cycle(); cycle(); done = 1'b1; cycle();
    cycle();
    auto_mode = 1'b0;
    cycle();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_val", 32'(jval), 32'd0);
    done = 1'b1;
    cycle();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_val", 32'(jval), 32'd0);

    // Out-of-range keys are ignored
    key = 3'd7; key_val = 1'b1;
    cycle();
    chk("range7_val", 32'(jval), 32'd0);
    key = 3'd6; key_val = 1'b1;
    cycle();
    chk("range6_val", 32'(jval), 32'd0);
    chk("range_busy", 32'(busy), 32'd0);

    // Programming entry 0 before enabling auto
    do_reset();
    prog_wr = 1'b1; prog_addr = 3'd0; prog_data = 3'd7;
    cycle();
    auto_mode = 1'b1;
    wait_strobe(4, n, num);
    chk("prog_num", 32'(num), 32'd7);

    // Mid-play reset: outputs cleared, playlist back to defaults
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst_val", 32'(jval), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_num", 32'(jnum), 32'd0);
    chk("mid_rst_pos", 32'(pos), 32'd0);
    rst = 1'b0;
    wait_strobe(4, n, num);
    chk("post_rst_num", 32'(num), 32'd0);
    chk("post_rst_pos", 32'(pos), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      key_val   = ($urandom_range(0, 11) == 0);
      key       = NW'($urandom_range(0, 7));
      done      = ($urandom_range(0, 3) == 0);
      prog_wr   = ($urandom_range(0, 15) == 0);
      prog_addr = PW'($urandom_range(0, SL - 1));
      prog_data = NW'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) auto_mode = ~auto_mode;
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jingle_sequencer.md
Name: jingle_sequencer

Overview:
- Controller in front of audio_send. Decides which jingle plays and when.
- Two sources of requests: manual jingle numbers from PS2_decoder, and an automatic playlist mode that steps through a programmable table of jingle numbers, with a fixed silent gap between entries.
- Issues one-cycle jingle_num/jingle_num_val commands to the player and tracks completion through a done pulse.

Parameters:
- JINGLE_CNT, 8, number of jingles stored in the player ROM.
- SEQ_LEN, 8, number of playlist entries.
- GAP_CYCLES, 48000, clk_i cycles of silence between playlist entries; must be >= 2.
- NUM_W, $clog2(JINGLE_CNT), derived width of a jingle number.
- POS_W, $clog2(SEQ_LEN), derived width of a playlist index.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- auto_mode_i  in  1  level; 1 = play the playlist continuously.
- key_num_i  in  NUM_W  manual jingle request number (from PS2_decoder).
- key_num_val_i  in  1  one-cycle strobe qualifying key_num_i.
- prog_wr_i  in  1  playlist write strobe.
- prog_addr_i  in  POS_W  playlist entry to write.
- prog_data_i  in  NUM_W  jingle number to store.
- jingle_done_i  in  1  one-cycle pulse from the player: current jingle has finished.
- jingle_num_o  out  NUM_W  jingle number command to audio_send.
- jingle_num_val_o  out  1  one-cycle strobe qualifying jingle_num_o.
- busy_o  out  1  high in START, PLAY and GAP.
- seq_pos_o  out  POS_W  current playlist index.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - state=IDLE; all outputs 0; gap counter 0.
  - Playlist entry i = i mod JINGLE_CNT.
  - Reset mid-play drops the current jingle with no further commands.
- States:
  - IDLE
  - START: drives jingle_num_val_o=1 for exactly one cycle with the latched number.
  - PLAY: waits for jingle_done_i.
  - GAP: counts GAP_CYCLES cycles.
- IDLE transitions:
  - key_num_val_i with key_num_i < JINGLE_CNT: latch key_num_i, go START, and record source=manual.
  - Otherwise, if auto_mode_i=1: latch playlist[seq_pos], go START, and record source=auto.
  - key_num_val_i has priority over auto_mode_i.
- Latency: request strobe at cycle N -> jingle_num_val_o=1 at cycle N+1; START -> PLAY at the next edge.
- PLAY transitions:
  - jingle_done_i with source=auto and auto_mode_i=1: go GAP and load the counter with GAP_CYCLES-1.
  - jingle_done_i in any other case: go IDLE.
- GAP transitions:
  - Counter decrements each cycle.
  - At counter 0: advance seq_pos (SEQ_LEN-1 wraps to 0), latch the new playlist entry, go START.
  - Total silence from done pulse to next strobe is GAP_CYCLES+1 cycles.
  - auto_mode_i=0 during GAP: go IDLE next cycle; seq_pos holds.
- Preemption: a valid key_num_val_i in PLAY or GAP latches the key number and goes START (source=manual). seq_pos is unchanged.
- Out-of-range key numbers: key_num_i >= JINGLE_CNT is ignored in every state.
- Ignored done pulses: jingle_done_i in IDLE, START or GAP is ignored. A done pulse coincident with a valid key strobe in PLAY loses to the key, which preempts.
- Playlist writes:
  - Accepted in any state; take effect from the next cycle.
  - A write to the entry being latched in the same cycle: the old value is issued.
- seq_pos_o: cleared only by reset; never cleared by leaving auto mode.
- Width rules: seq_pos wraps modulo SEQ_LEN (explicit compare, SEQ_LEN need not be a power of 2). Gap counter width is $clog2(GAP_CYCLES).

Decomposition:
- Package synth_pkg holds:
  - the state enum seq_state_t (IDLE, START, PLAY, GAP);
  - a source enum (SRC_MANUAL, SRC_AUTO).
- One natural sub-module: seq_playlist_ram, an SEQ_LEN x NUM_W register file with a synchronous write port, an asynchronous read port, and reset init i mod JINGLE_CNT.
- FSM and gap counter stay in jingle_sequencer.

Test Plan:
- Manual request: key_num_val_i=1, key_num_i=5 at cycle 10, auto_mode_i=0 -> jingle_num_o=5 with jingle_num_val_o=1 only at cycle 11; done pulse -> IDLE, busy_o=0.
- Auto playlist with GAP_CYCLES=4, default playlist, auto_mode_i=1:
  - Strobes carry 0,1,2,...
  - Each strobe follows its done pulse by 5 cycles.
  - After entry 7, seq_pos_o wraps to 0 and 0 is reissued.
- Preemption: during GAP of entry 2, key 6 -> strobe with 6 next cycle. After its done, GAP, then entry 3 plays (seq_pos unchanged).
- Programming and range check:
  - Write entry 0 = 7, then enable auto -> first strobe carries 7.
  - With JINGLE_CNT=6, key 7 -> no strobe.
- Mode drop: auto_mode_i falls in GAP -> IDLE with no strobe. jingle_done_i in IDLE -> no effect.
- Mid-play reset: rst_i=1 in PLAY -> next cycle all outputs 0. After release, playlist contents are defaults and seq_pos_o=0.
